crypto_wallet_stream_mem_writer: RTL and testbench
==================================================

// Module: crypto_wallet_stream_mem_writer
// PURPOSE
//  Upstream feeder for the 32-bit single-port on-chip RAM (13-bit word address, 6500 words, byte enables).
//  Accepts a byte stream (valid/ready/last), packs bytes little-endian into 32-bit words, and writes each word
//  to consecutive RAM addresses from a programmable base. A frame is the bytes up to and including in_last;
//  a trailing partial word is flushed with partial byteenable. Used to load keys/firmware blobs into RAM.
// PARAMETERS
//  ADDR_W   13    RAM word-address width
//  DEPTH    6500  RAM depth in words; writes to addresses >= DEPTH are suppressed
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       asynchronous, active-low reset
//  cfg_base        in   ADDR_W  first word address of frame; sampled on accepted start
//  start           in   1       one-cycle pulse; begins a frame; ignored while busy=1
//  in_data         in   8       stream byte
//  in_valid        in   1       in_data valid
//  in_ready        out  1       byte accepted when in_valid & in_ready
//  in_last         in   1       qualifies last byte of frame (frame always has >=1 byte)
//  mem_address     out  ADDR_W  RAM word address
//  mem_byteenable  out  4       lane enables; bit i <-> writedata[8i+7:8i]
//  mem_chipselect  out  1       equals mem_write
//  mem_write       out  1       one-cycle write strobe (RAM never stalls)
//  mem_writedata   out  32      packed word; unfilled lanes driven 0
//  mem_clken       out  1       1 when reset_n=1, else 0
//  busy            out  1       frame in progress
//  done            out  1       one-cycle pulse at end of frame
//  words_written   out  ADDR_W  writes issued this frame; cleared on start
//  err_overflow    out  1       sticky; set if any write suppressed; cleared on start
// BEHAVIOUR
//  Reset: all outputs 0 (mem_clken 0 while reset_n=0); FSM -> IDLE; lane count 0. Asserting reset mid-frame
//   aborts immediately, no pending write is issued, partial word discarded.
//  FSM: IDLE -(start)-> FILL -(accepted byte with in_last)-> FLUSH -> IDLE (done=1 in FLUSH cycle).
//   Overflow: in FILL, a word due at addr >= DEPTH sets err_overflow, write suppressed, go DRAIN.
//   DRAIN: in_ready=1, bytes discarded; accepted in_last -> FLUSH.
//  in_ready = 1 in FILL and DRAIN only; 0 in IDLE and FLUSH. busy = (state != IDLE).
//  Packing: k-th accepted byte of a word (k=0..3) goes to lane k; first byte of frame -> writedata[7:0].
//  Write issue: registered; on the cycle after accepting the 4th lane byte or any in_last byte,
//   mem_write=1 for exactly one cycle with address = base + word_index, byteenable = filled lanes
//   (4'b1111, 4'b0111, 4'b0011, 4'b0001). Lane count restarts same cycle as acceptance, so 1 byte/clk
//   sustained; in_ready never drops for write issue inside FILL.
//  Address: base + word_index computed ADDR_W+1 wide; overflow if sum >= DEPTH (includes cfg_base >= DEPTH).
//   No wrap-around. Once overflowed, no further writes in that frame.
//  words_written increments on each issued mem_write; saturates at DEPTH.
//  done pulses in FLUSH coincident with or after final mem_write; start accepted earliest next cycle.
//  start while busy: ignored, no effect on counters/flags. in_valid in IDLE: not accepted.
// STRUCTURE
//  Package crypto_wallet_mem_pkg: ADDR_W, DEPTH, DATA_W=32, BE_W=4, state enum {IDLE,FILL,DRAIN,FLUSH}.
//  Sub-module crypto_wallet_word_packer: byte->word lane accumulator (lane count, data, byteenable,
//   word_ready pulse, flush on last). Top holds FSM, address/overflow logic, counters, output regs.
// TESTING
//  1 base=0x010, bytes 01..08, last on 08 -> writes @0x010 0x04030201 be F, @0x011 0x08070605 be F;
//    done pulse; words_written=2; err_overflow=0.
//  2 base=0x020, bytes 11..16, last on 16 -> @0x020 0x14131211 be F, @0x021 0x00001615 be 3; words=2.
//  3 base=6499, bytes 01..05 -> @6499 0x04030201 be F only; err_overflow=1; byte 05 drained; done; words=1.
//  4 base=0, 16 bytes continuous in_valid=1 -> in_ready held 1, mem_write every 4th cycle at addr 0..3.
//  5 reset_n low after 2 bytes of frame -> all outputs 0 async, no write; then start base=5, 1 byte AA
//    -> @5 0x000000AA be 1.
//  6 start pulsed mid-frame and in_valid in IDLE -> ignored; counters unchanged; no byte accepted.

Source files
------------

// File: rtl/crypto_wallet_stream_mem_writer_pkg.sv
// Shared constants, FSM state type and lane-mask helper for the stream-to-RAM writer.
package crypto_wallet_mem_pkg;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 6500;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Byte enables for a word whose highest filled lane is last_lane.
    function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] last_lane);
        logic [BE_W-1:0] m;
        case (last_lane)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/crypto_wallet_stream_mem_writer_if.sv
// Byte-stream input and RAM write-port signals of the stream writer.
interface crypto_wallet_stream_mem_writer_if #(
    parameter int ADDR_W = crypto_wallet_mem_pkg::ADDR_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    // Stream source side; also observes the RAM port.
    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

    // Writer side: consumes the stream and drives the RAM port.
    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/crypto_wallet_stream_mem_writer_packer.sv
// Little-endian byte-to-word lane accumulator; flags a completed word combinationally.
module crypto_wallet_word_packer
    import crypto_wallet_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    input  logic              last,
    output logic              word_ready,
    output logic [DATA_W-1:0] word_data,
    output logic [BE_W-1:0]   word_be
);
    logic [1:0]        lane_p0;
    logic [DATA_W-1:0] acc_p0;

    // Merge the incoming byte into its lane; lanes above it are still zero.
    always_comb begin
        word_data = acc_p0;
        word_data[{lane_p0, 3'b000} +: 8] = byte_in;
        word_be    = lane_mask(lane_p0);
        word_ready = accept & ((lane_p0 == 2'd3) | last);
    end

    // Lane counter and accumulator restart in the same cycle a word completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_p0 <= 2'd0;
            acc_p0  <= '0;
        end else if (clr) begin
            lane_p0 <= 2'd0;
            acc_p0  <= '0;
        end else if (accept) begin
            if (word_ready) begin
                lane_p0 <= 2'd0;
                acc_p0  <= '0;
            end else begin
                lane_p0 <= lane_p0 + 2'd1;
                acc_p0  <= word_data;
            end
        end
    end
endmodule

// File: rtl/crypto_wallet_stream_mem_writer.sv
// Packs a byte stream into 32-bit words and writes them to consecutive RAM addresses.
module crypto_wallet_stream_mem_writer #(
    parameter int ADDR_W = crypto_wallet_mem_pkg::ADDR_W,
    parameter int DEPTH  = crypto_wallet_mem_pkg::DEPTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDR_W-1:0]               cfg_base,
    input  logic                            start,
    crypto_wallet_stream_mem_writer_if.slave bus,
    output logic                            busy,
    output logic                            done,
    output logic [ADDR_W-1:0]               words_written,
    output logic                            err_overflow
);
    import crypto_wallet_mem_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_SUM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_CNT = ADDR_W'(DEPTH);

    state_t              state_p0, state_nx;
    logic [ADDR_W-1:0]   base_p0;
    logic [ADDR_W:0]     word_idx_p0;
    logic [ADDR_W:0]     addr_sum;
    logic                addr_ovf;
    logic                in_ready_c;
    logic                start_ok;
    logic                accept;
    logic                drain_last;
    logic                word_ready;
    logic [DATA_W-1:0]   word_data;
    logic [BE_W-1:0]     word_be;
    logic                wr_vld_p1;
    logic [ADDR_W-1:0]   wr_addr_p1;
    logic [DATA_W-1:0]   wr_data_p1;
    logic [BE_W-1:0]     wr_be_p1;

    assign start_ok   = (state_p0 == IDLE) & start;
    assign accept     = bus.in_valid & in_ready_c & (state_p0 == FILL);
    assign drain_last = bus.in_valid & in_ready_c & bus.in_last & (state_p0 == DRAIN);
    // Widened sum so a base near the top of the address space never wraps.
    assign addr_sum   = {1'b0, base_p0} + word_idx_p0;
    assign addr_ovf   = (addr_sum >= DEPTH_SUM);

    crypto_wallet_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (start_ok),
        .accept     (accept),
        .byte_in    (bus.in_data),
        .last       (bus.in_last),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_be    (word_be)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_p0 <= IDLE;
        else          state_p0 <= state_nx;
    end

    // Next-state: an out-of-range word stops writing; the rest of the frame is drained.
    always_comb begin
        state_nx = state_p0;
        case (state_p0)
            IDLE:  if (start) state_nx = FILL;
            FILL: begin
                if (accept && bus.in_last)        state_nx = FLUSH;
                else if (word_ready && addr_ovf)  state_nx = DRAIN;
            end
            DRAIN: if (drain_last) state_nx = FLUSH;
            FLUSH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready_c = (state_p0 == FILL) || (state_p0 == DRAIN);
        busy       = (state_p0 != IDLE);
        done       = (state_p0 == FLUSH);
    end

    // Frame bookkeeping: base, word index, write count and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_p0       <= '0;
            word_idx_p0   <= '0;
            words_written <= '0;
            err_overflow  <= 1'b0;
        end else if (start_ok) begin
            base_p0       <= cfg_base;
            word_idx_p0   <= '0;
            words_written <= '0;
            err_overflow  <= 1'b0;
        end else if (accept && word_ready) begin
            if (addr_ovf) begin
                err_overflow <= 1'b1;
            end else begin
                word_idx_p0 <= word_idx_p0 + (ADDR_W+1)'(1);
                if (words_written != DEPTH_CNT)
                    words_written <= words_written + ADDR_W'(1);
            end
        end
    end

    // Stage p1: registered RAM write, one strobe per completed in-range word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            wr_be_p1   <= '0;
        end else begin
            wr_vld_p1 <= accept & word_ready & ~addr_ovf;
            if (accept && word_ready && !addr_ovf) begin
                wr_addr_p1 <= addr_sum[ADDR_W-1:0];
                wr_data_p1 <= word_data;
                wr_be_p1   <= word_be;
            end
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.mem_write      = wr_vld_p1;
    assign bus.mem_chipselect = wr_vld_p1;
    assign bus.mem_address    = wr_addr_p1;
    assign bus.mem_writedata  = wr_data_p1;
    assign bus.mem_byteenable = wr_be_p1;
    assign bus.mem_clken      = reset_n;
endmodule

// File: tb/tb_crypto_wallet_stream_mem_writer.sv
// Bench for the stream-to-RAM writer: directed table, hand sequences and random frames vs a word-level model.
module tb_crypto_wallet_stream_mem_writer;
    localparam int AW = 13;
    localparam int DP = 6500;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          cyc;
    } wr_t;

    typedef struct {
        int          base;
        int          n;
        int          b0;
        int          exp_words;
        bit          exp_ovf;
        int          exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic          busy, done, err_overflow;
    logic [AW-1:0] words_written;

    crypto_wallet_stream_mem_writer_if #(.ADDR_W(AW)) bus();

    crypto_wallet_stream_mem_writer #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_base      (cfg_base),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  done_cnt = 0;
    int  cs_bad = 0;
    wr_t got[$];
    int  total = 0;
    int  bad = 0;
    logic [7:0] fb [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the RAM port mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_write) got.push_back('{32'(bus.mem_address), bus.mem_writedata, bus.mem_byteenable, cyc});
        if (done) done_cnt <= done_cnt + 1;
        if (bus.mem_chipselect !== bus.mem_write) cs_bad <= cs_bad + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic do_frame(input int base, input int n, input bit gaps, input int mid_start,
                            output int stalls, output int g0, output int d0);
        stalls = 0;
        g0 = got.size();
        d0 = done_cnt;
        cfg_base = AW'(base);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_base = '0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_data  = fb[i];
            bus.in_last  = (i == n - 1);
            if (i == mid_start) begin
                start = 1'b1;
                cfg_base = AW'(7);
            end
            for (int t = 0; t < 50 && !bus.in_ready; t++) begin
                stalls++;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        for (int t = 0; t < 100 && done_cnt == d0; t++) begin
            @(posedge clk); #1;
        end
    endtask

    // Word-level model: ceil(n/4) words, lane k of word w is byte 4w+k, stop at the first address >= DP.
    task automatic check_model(input string tag, input int base, input int n, input int g0, input int d0);
        int          nw;
        int          w_exp;
        bit          ovf;
        int          cnt;
        logic [31:0] data;
        logic [3:0]  be;
        nw = (n + 3) / 4;
        w_exp = 0;
        ovf = 1'b0;
        for (int w = 0; w < nw; w++) begin
            if (base + w >= DP) begin
                ovf = 1'b1;
                break;
            end
            data = '0;
            cnt = 0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) begin
                    data[8*k +: 8] = fb[4*w+k];
                    cnt++;
                end
            end
            be = 4'((1 << cnt) - 1);
            if (g0 + w < got.size()) begin
                chk($sformatf("%s_addr%0d", tag, w), got[g0+w].addr, 32'(base + w));
                chk($sformatf("%s_data%0d", tag, w), got[g0+w].data, data);
                chk($sformatf("%s_be%0d", tag, w), 32'(got[g0+w].be), 32'(be));
            end
            w_exp++;
        end
        chk({tag, "_nwrites"}, 32'(got.size() - g0), 32'(w_exp));
        chk({tag, "_words"}, 32'(words_written), 32'(w_exp));
        chk({tag, "_ovf"}, 32'(err_overflow), 32'(ovf));
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vt[7];

    initial begin
        int stalls, g0, d0, w0, base, n, last;

        vt[0] = '{32'h010, 8, 8'h01, 2, 1'b0, 32'h011, 32'h08070605, 4'hF};
        vt[1] = '{32'h020, 6, 8'h11, 2, 1'b0, 32'h021, 32'h00001615, 4'h3};
        vt[2] = '{6499,    5, 8'h01, 1, 1'b1, 6499,    32'h04030201, 4'hF};
        vt[3] = '{6498,    4, 8'hA0, 1, 1'b0, 6498,    32'hA3A2A1A0, 4'hF};
        vt[4] = '{6500,    3, 8'h30, 0, 1'b1, 0,       32'h0,        4'h0};
        vt[5] = '{32'h100, 1, 8'h55, 1, 1'b0, 32'h100, 32'h00000055, 4'h1};
        vt[6] = '{32'h200, 7, 8'h70, 2, 1'b0, 32'h201, 32'h00767574, 4'h7};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset state.
        #1;
        chk("rst_clken", 32'(bus.mem_clken), 32'd0);
        chk("rst_write", 32'(bus.mem_write), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        chk("rst_ovf", 32'(err_overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("clken_up", 32'(bus.mem_clken), 32'd1);

        // Directed frame table.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vt[v].n; i++) fb[i] = 8'(vt[v].b0 + i);
            do_frame(vt[v].base, vt[v].n, 1'b0, -1, stalls, g0, d0);
            chk($sformatf("vec%0d_nwrites", v), 32'(got.size() - g0), 32'(vt[v].exp_words));
            if (vt[v].exp_words > 0 && got.size() > g0) begin
                last = got.size() - 1;
                chk($sformatf("vec%0d_last_addr", v), got[last].addr, 32'(vt[v].exp_addr));
                chk($sformatf("vec%0d_last_data", v), got[last].data, vt[v].exp_data);
                chk($sformatf("vec%0d_last_be", v), 32'(got[last].be), 32'(vt[v].exp_be));
            end
            chk($sformatf("vec%0d_words", v), 32'(words_written), 32'(vt[v].exp_words));
            chk($sformatf("vec%0d_ovf", v), 32'(err_overflow), 32'(vt[v].exp_ovf));
            chk($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'd1);
            check_model($sformatf("vec%0d", v), vt[v].base, vt[v].n, g0, d0);
        end

        // Sustained 1 byte/clk: no stalls, one write every 4 cycles.
        for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
        do_frame(0, 16, 1'b0, -1, stalls, g0, d0);
        chk("stream_stalls", 32'(stalls), 32'd0);
        check_model("stream", 0, 16, g0, d0);
        if (got.size() >= g0 + 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("stream_gap%0d", i), 32'(got[g0+i].cyc - got[g0+i-1].cyc), 32'd4);
        end

        // Reset mid-frame after two bytes.
        g0 = got.size();
        cfg_base = AW'(12'h040);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC1;
        @(posedge clk); #1;
        bus.in_data  = 8'hC2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_clken", 32'(bus.mem_clken), 32'd0);
        chk("abort_write", 32'(bus.mem_write), 32'd0);
        chk("abort_addr", 32'(bus.mem_address), 32'd0);
        chk("abort_wdata", bus.mem_writedata, 32'd0);
        chk("abort_be", 32'(bus.mem_byteenable), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_nowrite", 32'(got.size() - g0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        fb[0] = 8'hAA;
        do_frame(5, 1, 1'b0, -1, stalls, g0, d0);
        check_model("after_abort", 5, 1, g0, d0);

        // start while busy is ignored; in_valid in IDLE is not accepted.
        for (int i = 0; i < 6; i++) fb[i] = 8'(8'h60 + i);
        do_frame(32'h300, 6, 1'b0, 2, stalls, g0, d0);
        check_model("start_busy", 32'h300, 6, g0, d0);
        w0 = 32'(words_written);
        g0 = got.size();
        d0 = done_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_ready%0d", i), 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_words", 32'(words_written), 32'(w0));
        chk("idle_nowrite", 32'(got.size() - g0), 32'd0);
        chk("idle_nodone", 32'(done_cnt - d0), 32'd0);

        // Random frames with input gaps, bases spread and clustered near the RAM end.
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 2))
                0:       base = $urandom_range(0, 200);
                1:       base = $urandom_range(6480, 6505);
                default: base = $urandom_range(0, 8191);
            endcase
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
            do_frame(base, n, 1'b1, -1, stalls, g0, d0);
            check_model($sformatf("rnd%0d", f), base, n, g0, d0);
        end

        chk("chipselect", 32'(cs_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
